ifu_inst_queue: RTL
===================

IFU_INST_QUEUE -- requirements
Module: ifu_inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of instruction entries (power of two, ≥2).
REQ-002 SHALL have parameter AW, default 64, meaning the instruction address width.
REQ-003 SHALL have port Clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port ReadShakeHands  input  1  the bus read response is valid this cycle.
REQ-006 SHALL have port BusRAddr  input  AW  the fetch address presented with the response (prefetch PC output).
REQ-007 SHALL have port BusRData  input  32  the fetched instruction.
REQ-008 SHALL have port Pc  input  AW  the architectural PC requested by the pipeline.
REQ-009 SHALL have port PcValid  input  1  Pc is meaningful this cycle.
REQ-010 SHALL have port IdReady  input  1  the decode stage accepts the instruction.
REQ-011 SHALL have port InstOut  output  32  the head instruction.
REQ-012 SHALL have port InstAddrOut  output  AW  the head address.
REQ-013 SHALL have port InstValid  output  1  the head hits Pc.
REQ-014 SHALL have port CacheMissing  output  1  one-cycle redirect request to the prefetch PC stage.
REQ-015 SHALL have port JumpAddr  output  AW  the redirect target, valid while CacheMissing=1.
REQ-016 SHALL have port CacheFull  output  1  back-pressure to the prefetch PC stage.

Function
REQ-017 SHALL store entries {addr, inst} in a circular buffer with read pointer, write pointer and a count of 0..DEPTH; pointers wrap modulo DEPTH.
REQ-018 SHALL combinationally set InstValid = PcValid & (count≠0) & (head.addr==Pc) & (state==RUN); InstOut and InstAddrOut always show the head.
REQ-019 SHALL pop the head when InstValid & IdReady.
REQ-020 SHALL push {BusRAddr, BusRData} when ReadShakeHands is high and any of the following holds: state==RUN; or state==REFILL with BusRAddr==JumpAddr.
REQ-021 SHALL accept a push when count==DEPTH only if a pop occurs in the same cycle; otherwise the response is dropped.
REQ-022 SHALL drive CacheFull = (count ≥ DEPTH-1) combinationally, reserving one slot for an in-flight response.
REQ-023 SHALL implement a state machine with states RUN and REFILL, both leaving reset as RUN.
REQ-024 SHALL, in RUN when PcValid & count≠0 & head.addr≠Pc: register CacheMissing=1 for exactly one cycle, register JumpAddr=Pc, clear count and both pointers, and go to REFILL.
REQ-025 SHALL NOT raise a miss in RUN when count==0; the block waits for the next response.
REQ-026 SHALL, in REFILL, discard responses whose BusRAddr≠JumpAddr (stale prefetches) and keep CacheMissing at 0.
REQ-027 SHALL, in REFILL on a response with BusRAddr==JumpAddr, push it and return to RUN; it may hit one cycle later.
REQ-028 SHALL, when a miss and a push coincide, give the miss priority: the response is discarded unless it matches Pc.
REQ-029 SHALL compute pointer and count arithmetic in exactly log2(DEPTH) and log2(DEPTH)+1 bits, with no overflow.

Reset
REQ-030 SHALL, while Rst=0, clear count and pointers, set state to RUN, CacheMissing=0 and JumpAddr=0; InstValid=0 and CacheFull=0 follow from count=0.
REQ-031 SHALL, on reset mid-refill, abandon the refill; stored entries are not required to be cleared, only the valid state.

Configuration
REQ-032 SHALL, when IFU_QUEUE_PERF_EN is defined, add outputs HitCount and MissCount (32 bits each, reset 0, wrapping), incrementing on each pop and each CacheMissing pulse respectively.
REQ-033 SHALL, when IFU_QUEUE_PERF_EN is undefined, contain neither those ports nor the counters.

Verification
REQ-034 SHALL cover sequential hit: push 0x80000000, 0x80000004; Pc=0x80000000, IdReady=1 -> InstValid=1 two consecutive cycles, count returns to 0.
REQ-035 SHALL cover full: DEPTH=4, three pushes with no pop -> CacheFull=1; a fourth push is accepted, a fifth is dropped, count=4.
REQ-036 SHALL cover miss: head 0x80000008, Pc=0x80000100 -> CacheMissing one cycle, JumpAddr=0x80000100, count=0, state REFILL.
REQ-037 SHALL cover stale discard: in REFILL, responses 0x8000000C and 0x80000010 are dropped; 0x80000100 is pushed, then InstValid=1 on the next cycle.
REQ-038 SHALL cover the miss/push collision: miss cycle with a simultaneous response of addr≠Pc -> response dropped, single CacheMissing pulse.
REQ-039 SHALL cover reset mid-refill: Rst=0 for one cycle during REFILL -> state RUN, count=0, CacheMissing=0.

Source files
------------

// File: rtl/ifu_inst_queue.sv
// Instruction queue between the bus read response and decode: buffers {addr, inst}
// pairs, hits on the architectural Pc and requests a redirect on a miss. Perf counters behind IFU_QUEUE_PERF_EN.
module ifu_inst_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 64
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     ReadShakeHands,
  input  logic [AW-1:0]            BusRAddr,
  input  logic [31:0]              BusRData,
  input  logic [AW-1:0]            Pc,
  input  logic                     PcValid,
  input  logic                     IdReady,
  output logic [31:0]              InstOut,
  output logic [AW-1:0]            InstAddrOut,
  output logic                     InstValid,
  output logic                     CacheMissing,
  output logic [AW-1:0]            JumpAddr,
  output logic                     CacheFull,
`ifdef IFU_QUEUE_PERF_EN
  output logic [31:0]              HitCount,
  output logic [31:0]              MissCount,
`endif
  output logic                     fsm_state,
  output logic [$clog2(DEPTH):0]   fill_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN = 1'b0, REFILL = 1'b1} state_t;

  state_t          state, state_next;
  logic [PW-1:0]   rd_ptr, wr_ptr, rd_next, wr_next;
  logic [CW-1:0]   count, count_next;
  logic [AW-1:0]   jump_next;
  logic            miss, pop, push;
  logic [AW-1:0]   mem_addr [DEPTH];
  logic [31:0]     mem_inst [DEPTH];

  // Handshake: ReadShakeHands is a valid-only strobe (CacheFull is advance warning,
  // not a ready), and the head leaves the queue only on InstValid & IdReady.
  assign InstOut     = mem_inst[rd_ptr];
  assign InstAddrOut = mem_addr[rd_ptr];
  assign InstValid   = PcValid && (count != '0) && (InstAddrOut == Pc) && (state == RUN);
  assign miss        = PcValid && (count != '0) && (InstAddrOut != Pc) && (state == RUN);
  assign pop         = InstValid && IdReady;
  assign CacheFull   = (count >= CW'(DEPTH - 1));
  assign fsm_state   = (state == REFILL);
  assign fill_count  = count;

  always_comb begin
    state_next = state;
    rd_next    = rd_ptr;
    wr_next    = wr_ptr;
    count_next = count;
    jump_next  = JumpAddr;
    push       = 1'b0;
    case (state)
      RUN: begin
        if (miss) begin
          jump_next  = Pc;
          rd_next    = '0;
          wr_next    = '0;
          count_next = '0;
          state_next = REFILL;
          // A response that already carries the target completes the refill at once.
          if (ReadShakeHands && (BusRAddr == Pc)) begin
            push       = 1'b1;
            wr_next    = PW'(1);
            count_next = CW'(1);
            state_next = RUN;
          end
        end else begin
          push = ReadShakeHands && ((count != CW'(DEPTH)) || pop);
          if (push) wr_next = wr_ptr + PW'(1);
          if (pop)  rd_next = rd_ptr + PW'(1);
          count_next = count + CW'(push) - CW'(pop);
        end
      end
      REFILL: begin
        if (ReadShakeHands && (BusRAddr == JumpAddr)) begin
          push       = 1'b1;
          wr_next    = wr_ptr + PW'(1);
          count_next = count + CW'(1);
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state        <= RUN;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      CacheMissing <= 1'b0;
      JumpAddr     <= '0;
    end else begin
      state        <= state_next;
      rd_ptr       <= rd_next;
      wr_ptr       <= wr_next;
      count        <= count_next;
      CacheMissing <= miss;
      JumpAddr     <= jump_next;
    end
  end

  // Storage is not reset; validity is carried entirely by count.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem_addr[miss ? '0 : wr_ptr] <= BusRAddr;
      mem_inst[miss ? '0 : wr_ptr] <= BusRData;
    end
  end

`ifdef IFU_QUEUE_PERF_EN
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      HitCount  <= '0;
      MissCount <= '0;
    end else begin
      if (pop)  HitCount  <= HitCount + 32'd1;
      if (miss) MissCount <= MissCount + 32'd1;
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule
